// File: rtl/collision_pkg.sv
// Shared types for the collision event manager: source ids, FSM states, event record.
// Optional coordinate capture is controlled by COLL_CAPTURE_XY_EN in the design files.
package collision_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned COORD_W_DEF = 11;

  typedef enum logic [1:0] {
    SRC_SHOT_ALIEN   = 2'd0,
    SRC_BOMB_PLAYER  = 2'd1,
    SRC_ALIEN_PLAYER = 2'd2,
    SRC_SHOT_SHIELD  = 2'd3
  } coll_src_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT
  } coll_state_t;

  typedef struct packed {
    coll_src_t                src;
    logic [CNT_W_DEF-1:0]     count;
    logic [COORD_W_DEF-1:0]   x;
    logic [COORD_W_DEF-1:0]   y;
  } coll_event_t;

endpackage

// File: rtl/collision_event_manager_if.sv
// Event valid/ack handshake between the collision manager (master) and game logic (slave).
interface collision_event_manager_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned COORD_W = 11
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic               eventValid;
  logic [SRC_W-1:0]   eventSrc;
  logic [CNT_W-1:0]   eventCount;
  logic [COORD_W-1:0] eventX;
  logic [COORD_W-1:0] eventY;
  logic               eventAck;

  modport master (
    output eventValid, eventSrc, eventCount, eventX, eventY,
    input  eventAck
  );

  modport slave (
    input  eventValid, eventSrc, eventCount, eventX, eventY,
    output eventAck
  );
endinterface

// File: rtl/collision_event_manager_src_latch.sv
// One collision source: collect bank (hit flag, saturating count) and report bank.
// COLL_CAPTURE_XY_EN adds first-hit coordinate capture per frame.
module collision_src_latch
  import collision_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               i_collide,
  input  logic               i_sof,
  input  logic               i_xfer,
  input  logic               i_clr,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_hit,
  output logic               o_rep_hit,
  output logic [CNT_W-1:0]   o_rep_cnt,
  output logic [COORD_W-1:0] o_rep_x,
  output logic [COORD_W-1:0] o_rep_y
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_hit;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rep_hit;
  logic [CNT_W-1:0] r_rep_cnt;

  // A collide coinciding with startOfFrame opens the new frame's collection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit <= 1'b0;
      r_cnt <= '0;
    end else if (i_sof) begin
      r_hit <= i_collide;
      r_cnt <= i_collide ? CNT_W'(1) : '0;
    end else if (i_collide) begin
      r_hit <= 1'b1;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rep_hit <= 1'b0;
      r_rep_cnt <= '0;
    end else if (i_sof && i_xfer) begin
      r_rep_hit <= r_hit;
      r_rep_cnt <= r_cnt;
    end else if (i_clr) begin
      r_rep_hit <= 1'b0;
      r_rep_cnt <= '0;
    end
  end

`ifdef COLL_CAPTURE_XY_EN
  logic [COORD_W-1:0] r_x, r_y, r_rep_x, r_rep_y;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_x     <= '0;
      r_y     <= '0;
      r_rep_x <= '0;
      r_rep_y <= '0;
    end else begin
      if (i_sof) begin
        r_x <= i_collide ? i_x : '0;
        r_y <= i_collide ? i_y : '0;
      end else if (i_collide && !r_hit) begin
        r_x <= i_x;
        r_y <= i_y;
      end
      if (i_sof && i_xfer) begin
        r_rep_x <= r_x;
        r_rep_y <= r_y;
      end else if (i_clr) begin
        r_rep_x <= '0;
        r_rep_y <= '0;
      end
    end
  end

  assign o_rep_x = r_rep_x;
  assign o_rep_y = r_rep_y;
`else
  logic w_unused_xy;
  assign w_unused_xy = ^{i_x, i_y};
  assign o_rep_x     = '0;
  assign o_rep_y     = '0;
`endif

  assign o_hit     = r_hit;
  assign o_rep_hit = r_rep_hit;
  assign o_rep_cnt = r_rep_cnt;
endmodule

// File: rtl/collision_event_manager.sv
// Turns per-pixel collide flags into per-frame events serialised over a valid/ack handshake.
// COLL_CAPTURE_XY_EN enables the pixel delay line and first-hit coordinate reporting.
module collision_event_manager
  import collision_pkg::*;
#(
  parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned COLL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_SRC-1:0]   collide,
  input  logic [COORD_W-1:0]   pixelX,
  input  logic [COORD_W-1:0]   pixelY,
  collision_event_manager_if.master evt,
  output logic                 frameOverrun
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [COORD_W-1:0] w_xd, w_yd;

`ifdef COLL_CAPTURE_XY_EN
  logic [COORD_W-1:0] r_xd [COLL_LAT];
  logic [COORD_W-1:0] r_yd [COLL_LAT];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < COLL_LAT; i++) begin
        r_xd[i] <= '0;
        r_yd[i] <= '0;
      end
    end else begin
      r_xd[0] <= pixelX;
      r_yd[0] <= pixelY;
      for (int unsigned i = 1; i < COLL_LAT; i++) begin
        r_xd[i] <= r_xd[i-1];
        r_yd[i] <= r_yd[i-1];
      end
    end
  end

  assign w_xd = r_xd[COLL_LAT-1];
  assign w_yd = r_yd[COLL_LAT-1];
`else
  localparam int unsigned lat_unused = COLL_LAT;
  logic w_unused_pix;
  assign w_unused_pix = ^{pixelX, pixelY};
  assign w_xd = '0;
  assign w_yd = '0;
`endif

  coll_state_t        r_state, w_state_nxt;
  logic               r_valid, w_valid_nxt;
  logic [SRC_W-1:0]   r_src, w_src_nxt, w_sel;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [COORD_W-1:0] r_x, w_x_nxt, r_y, w_y_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               w_sel_found;
  logic [NUM_SRC-1:0] w_hit, w_rep_hit, w_clr;
  logic [CNT_W-1:0]   w_rep_cnt [NUM_SRC];
  logic [COORD_W-1:0] w_rep_x [NUM_SRC];
  logic [COORD_W-1:0] w_rep_y [NUM_SRC];
  logic               w_xfer;

  // Report bank only reloads when the previous frame's events are fully drained.
  assign w_xfer = (r_state == ST_IDLE);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    collision_src_latch #(.CNT_W(CNT_W), .COORD_W(COORD_W)) u_latch (
      .clk       (clk),
      .resetN    (resetN),
      .i_collide (collide[g]),
      .i_sof     (startOfFrame),
      .i_xfer    (w_xfer),
      .i_clr     (w_clr[g]),
      .i_x       (w_xd),
      .i_y       (w_yd),
      .o_hit     (w_hit[g]),
      .o_rep_hit (w_rep_hit[g]),
      .o_rep_cnt (w_rep_cnt[g]),
      .o_rep_x   (w_rep_x[g]),
      .o_rep_y   (w_rep_y[g])
    );
  end

  always_comb begin
    w_sel       = '0;
    w_sel_found = 1'b0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (w_rep_hit[i-1]) begin
        w_sel       = SRC_W'(i-1);
        w_sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_src_nxt     = r_src;
    w_cnt_nxt     = r_cnt;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_clr         = '0;
    w_overrun_nxt = startOfFrame && (r_state != ST_IDLE) && (|w_hit);
    unique case (r_state)
      ST_IDLE: begin
        if (startOfFrame && (|w_hit)) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_sel_found) begin
          w_state_nxt = ST_PRESENT;
          w_valid_nxt = 1'b1;
          w_src_nxt   = w_sel;
          w_cnt_nxt   = w_rep_cnt[w_sel];
          w_x_nxt     = w_rep_x[w_sel];
          w_y_nxt     = w_rep_y[w_sel];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (evt.eventAck) begin
          w_clr[r_src] = 1'b1;
          w_valid_nxt  = 1'b0;
          w_src_nxt    = '0;
          w_cnt_nxt    = '0;
          w_x_nxt      = '0;
          w_y_nxt      = '0;
          w_state_nxt  = (|(w_rep_hit & ~w_clr)) ? ST_SCAN : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_src     <= '0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_src     <= w_src_nxt;
      r_cnt     <= w_cnt_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign evt.eventValid = r_valid;
  assign evt.eventSrc   = r_src;
  assign evt.eventCount = r_cnt;
  assign evt.eventX     = r_x;
  assign evt.eventY     = r_y;
  assign frameOverrun   = r_overrun;
endmodule
